conv_sequencer: RTL and testbench
=================================

Name: conv_sequencer

Overview:
Frame-level controller for the convolution layer datapath (window shift registers feeding multiply-adder trees). It accepts a raster-order pixel stream with a valid/ready handshake, forwards each pixel to the window shift registers with a shift enable, and tracks row/column position. It tags which tree outputs correspond to fully populated, non-wrapping windows and delays each tag to line up with the adder-tree pipeline. It sits between the upstream pixel source and the convolution layer, and drives out_valid plus output coordinates to the next layer.

Parameters:
IMG_W, 32, image width in pixels (>= KERNEL_W)
IMG_H, 32, image height in pixels (>= KERNEL_H)
KERNEL_W, 3, window width; equals the layer's parallel shift register depth
KERNEL_H, 3, window height; equals the layer's number of shift register rows
MA_LATENCY, 4, clock cycles from window change to tree output change
COL_W, $clog2(IMG_W), column counter width
ROW_W, $clog2(IMG_H), row counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE
in_valid  in  1  upstream pixel valid
in_ready  out  1  sequencer accepts a pixel this cycle
pixel_in  in  8  upstream pixel
conv_pixel  out  8  registered pixel to the layer shift_in
conv_shift_en  out  1  registered shift enable for the layer shift registers
out_valid  out  1  tree outputs hold a valid window result this cycle
out_row  out  ROW_W  output-map row of the current result
out_col  out  COL_W  output-map column of the current result
busy  out  1  high in FEED and DRAIN
done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; all outputs 0; counters, tag delay line and coordinate pipeline cleared. Deasserting reset mid-frame leaves the sequencer in IDLE; the partial frame is discarded with no out_valid and no done.
- A pixel is accepted on a cycle where in_valid and in_ready are both 1. in_ready = 1 only in FEED and is combinational from state only, with no dependency on in_valid.
- IDLE: in_ready=0. start=1 moves to FEED and zeroes row and col. in_valid is ignored.
- FEED: on acceptance, conv_pixel <= pixel_in and conv_shift_en <= 1 on the next edge. conv_shift_en is 0 on any cycle following a non-accept. col increments and wraps to 0 at IMG_W-1; row increments on that wrap. Accepting pixel (IMG_H-1, IMG_W-1) moves to DRAIN.
- Window tag at acceptance: tag = (row >= KERNEL_H-1) && (col >= KERNEL_W-1). Tag coordinates are (row-KERNEL_H+1, col-KERNEL_W+1).
- The tag and its coordinates enter a delay line of LAT = MA_LATENCY+2 stages: 1 for the output register, 1 for the shift, and MA_LATENCY for the tree. The delay line advances every clock, whether or not a pixel is accepted.
- out_valid, out_row and out_col come from the last delay stage. out_valid for a pixel accepted at cycle t appears at cycle t+LAT for exactly 1 cycle. out_row and out_col are 0 whenever out_valid=0.
- Upstream gaps (in_valid=0) hold the shift registers. Each result is reported exactly once.
- DRAIN: in_ready=0. The sequencer counts LAT cycles after the final acceptance, then moves to DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- busy = 1 in FEED and DRAIN; 0 in IDLE and DONE.
- start while not in IDLE is ignored.
- Results per frame: (IMG_H-KERNEL_H+1)*(IMG_W-KERNEL_W+1) out_valid pulses, in raster order.

Test Plan:
All scenarios use IMG_W=IMG_H=5, KERNEL 3x3, MA_LATENCY=4, LAT=6.
- Reset then idle, in_valid=1 with no start -> in_ready, conv_shift_en, out_valid, busy and done all remain 0.
- start, then 25 pixels with in_valid held high (values 1..25) -> conv_pixel follows 1 cycle after each accept. Exactly 9 out_valid pulses. The first pulse comes 6 cycles after accepting pixel 13 (row 2, col 2), with coords (0,0). The last has coords (2,2). done pulses 7 cycles after the 25th accept.
- Same frame with in_valid low every other cycle -> still 9 pulses, each 6 cycles after its enabling accept. conv_shift_en is low in the gap cycles.
- start pulsed again during FEED and during DRAIN -> ignored; counts and done timing unchanged.
- reset asserted after 14 accepts, then released, then a new start with a full frame -> no out_valid or done from the aborted frame. The new frame yields exactly 9 pulses, first at coords (0,0).
- Column wrap check -> no out_valid for accepts at col 0 or col 1 of any row, or in rows 0 and 1.

Source files
------------

// File: rtl/conv_sequencer.sv
// conv_sequencer: pixel-stream frame controller that feeds the conv window registers and tags valid tree outputs
module conv_sequencer #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int KERNEL_W   = 3,
    parameter int KERNEL_H   = 3,
    parameter int MA_LATENCY = 4,
    parameter int COL_W      = $clog2(IMG_W),
    parameter int ROW_W      = $clog2(IMG_H)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       pixel_in,
    output logic [7:0]       conv_pixel,
    output logic             conv_shift_en,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             busy,
    output logic             done
);
    localparam int LAT   = MA_LATENCY + 2;
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [COL_W-1:0] W1  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] H1  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] KW1 = COL_W'(KERNEL_W - 1);
    localparam logic [ROW_W-1:0] KH1 = ROW_W'(KERNEL_H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [CNT_W-1:0] cnt;
    logic [LAT-1:0]   v_pipe;
    logic [ROW_W-1:0] r_pipe [LAT];
    logic [COL_W-1:0] c_pipe [LAT];
    logic accept, tag, last_px;

    assign in_ready  = state == S_FEED;
    assign accept    = in_valid && in_ready;
    assign tag       = accept && row >= KH1 && col >= KW1;
    assign last_px   = row == H1 && col == W1;
    assign out_valid = v_pipe[LAT-1];
    assign out_row   = r_pipe[LAT-1];
    assign out_col   = c_pipe[LAT-1];

    // Coordinates ride the delay line zeroed when untagged, so the outputs read 0 whenever out_valid is low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            row           <= '0;
            col           <= '0;
            cnt           <= '0;
            conv_pixel    <= '0;
            conv_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            v_pipe        <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_pipe[i] <= '0;
                c_pipe[i] <= '0;
            end
        end else begin
            conv_shift_en <= accept;
            if (accept) conv_pixel <= pixel_in;
            v_pipe    <= {v_pipe[LAT-2:0], tag};
            r_pipe[0] <= tag ? row - KH1 : '0;
            c_pipe[0] <= tag ? col - KW1 : '0;
            for (int i = 1; i < LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
                c_pipe[i] <= c_pipe[i-1];
            end
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_FEED;
                    row   <= '0;
                    col   <= '0;
                    busy  <= 1'b1;
                end
                S_FEED: if (accept) begin
                    col <= col == W1 ? '0 : col + 1'b1;
                    row <= col == W1 ? row + 1'b1 : row;
                    if (last_px) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end
                end
                S_DRAIN: if (cnt == CNT_LAST) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: randomized frames checked cycle by cycle against a scheduled-event model
module tb_conv_sequencer;
    localparam int W = 5, H = 5, KW = 3, KH = 3, MAL = 4, LAT = MAL + 2;
    localparam int NPIX = W * H, MAXC = 400;

    logic clock = 0, rst_n = 0, start = 0, in_valid = 0;
    logic [7:0] pixel_in = 0;
    logic in_ready, conv_shift_en, out_valid, busy, done;
    logic [7:0] conv_pixel;
    logic [2:0] out_row, out_col;
    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    conv_sequencer #(.IMG_W(W), .IMG_H(H), .KERNEL_W(KW), .KERNEL_H(KH), .MA_LATENCY(MAL)) dut (
        .clock(clock), .reset(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_in(pixel_in), .conv_pixel(conv_pixel), .conv_shift_en(conv_shift_en),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    // Model: each accept of raster index k schedules its shift, result and (for the last) done at fixed offsets
    task automatic run_frame(input int gap, input bit poke, input string name);
        bit ev_v[MAXC], ev_se[MAXC], ev_done[MAXC];
        int ev_r[MAXC], ev_c[MAXC];
        bit [7:0] ev_px[MAXC];
        int k = 0, last = -1, pulses = 0;
        bit ok_end = 0;
        for (int n = 0; n < MAXC; n++) begin
            bit feed, exp_busy;
            @(posedge clock); #1;
            feed     = n >= 1 && k < NPIX;
            exp_busy = n >= 1 && (last < 0 || n <= last + LAT);
            start    = (n == 0) || (poke && exp_busy && $urandom_range(0, 2) == 0);
            in_valid = gap == 0 ? 1'b1 : gap == 1 ? (n % 2 == 1) : 1'($urandom_range(0, 1));
            pixel_in = gap == 2 || !in_valid ? 8'($urandom) : 8'(k + 1);
            checks++;
            if (in_ready !== feed) begin errors++; $display("FAIL %s in_ready cyc %0d got %b exp %b", name, n, in_ready, feed); end
            checks++;
            if (conv_shift_en !== ev_se[n]) begin errors++; $display("FAIL %s shift_en cyc %0d got %b exp %b", name, n, conv_shift_en, ev_se[n]); end
            if (ev_se[n]) begin
                checks++;
                if (conv_pixel !== ev_px[n]) begin errors++; $display("FAIL %s conv_pixel cyc %0d got %0d exp %0d", name, n, conv_pixel, ev_px[n]); end
            end
            checks++;
            if (out_valid !== ev_v[n] || out_row !== 3'(ev_r[n]) || out_col !== 3'(ev_c[n])) begin
                errors++;
                $display("FAIL %s result cyc %0d got v=%b (%0d,%0d) exp v=%b (%0d,%0d)", name, n, out_valid, out_row, out_col, ev_v[n], ev_r[n], ev_c[n]);
            end
            checks++;
            if (busy !== exp_busy) begin errors++; $display("FAIL %s busy cyc %0d got %b exp %b", name, n, busy, exp_busy); end
            checks++;
            if (done !== ev_done[n]) begin errors++; $display("FAIL %s done cyc %0d got %b exp %b", name, n, done, ev_done[n]); end
            pulses += int'(out_valid === 1'b1);
            if (feed && in_valid && n + LAT + 1 < MAXC) begin
                int r, c;
                r = k / W;
                c = k % W;
                ev_se[n+1] = 1;
                ev_px[n+1] = pixel_in;
                if (r >= KH - 1 && c >= KW - 1) begin
                    ev_v[n+LAT] = 1;
                    ev_r[n+LAT] = r - KH + 1;
                    ev_c[n+LAT] = c - KW + 1;
                end
                k++;
                if (k == NPIX) begin
                    last = n;
                    ev_done[n+LAT+1] = 1;
                end
            end
            if (last >= 0 && n == last + LAT + 4) begin
                ok_end = 1;
                break;
            end
        end
        start = 0;
        in_valid = 0;
        checks++;
        if (!ok_end) begin errors++; $display("FAIL %s frame_end timeout got %0d accepts exp %0d", name, k, NPIX); end
        checks++;
        if (pulses != (H - KH + 1) * (W - KW + 1)) begin errors++; $display("FAIL %s pulse_count got %0d exp %0d", name, pulses, (H - KH + 1) * (W - KW + 1)); end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({in_ready, conv_shift_en, out_valid, busy, done, conv_pixel, out_row, out_col} !== '0) begin
            errors++; $display("FAIL reset_state got %b exp 0", {in_ready, conv_shift_en, out_valid, busy, done, conv_pixel, out_row, out_col});
        end
        rst_n = 1;
        in_valid = 1;
        pixel_in = 8'h5a;
        for (int n = 0; n < 10; n++) begin
            @(posedge clock); #1;
            checks++;
            if ({in_ready, conv_shift_en, out_valid, busy, done} !== 5'b0) begin
                errors++; $display("FAIL idle_no_start cyc %0d got %b exp 00000", n, {in_ready, conv_shift_en, out_valid, busy, done});
            end
        end
        in_valid = 0;
    endtask

    task automatic test_full();
        run_frame(0, 0, "full");
    endtask

    task automatic test_gaps();
        run_frame(1, 0, "gaps");
    endtask

    task automatic test_start_ignored();
        run_frame(0, 1, "start_poke");
        run_frame(2, 1, "start_poke_rand");
    endtask

    task automatic test_col_wrap();
        for (int i = 0; i < 3; i++) run_frame(2, 0, "col_wrap_rand");
    endtask

    task automatic test_abort();
        for (int n = 0; n < 15; n++) begin
            @(posedge clock); #1;
            start = n == 0;
            in_valid = n >= 1;
            pixel_in = 8'(n);
        end
        @(posedge clock); #1;
        start = 0;
        in_valid = 0;
        rst_n = 0;
        #1;
        checks++;
        if ({in_ready, conv_shift_en, out_valid, busy, done, conv_pixel} !== '0) begin
            errors++; $display("FAIL abort_reset got %b exp 0", {in_ready, conv_shift_en, out_valid, busy, done, conv_pixel});
        end
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1;
        in_valid = 1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            checks++;
            if ({in_ready, out_valid, busy, done} !== 4'b0) begin
                errors++; $display("FAIL abort_quiet cyc %0d got %b exp 0000", n, {in_ready, out_valid, busy, done});
            end
        end
        in_valid = 0;
        run_frame(0, 0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_full();
        test_gaps();
        test_start_ignored();
        test_abort();
        test_col_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
